// File: rtl/cam2vga_pkg.sv
// rtl/cam2vga_pkg.sv - shared pixel formats and pipeline constants for the camera-to-VGA path
package cam2vga_pkg;

   localparam int HSV_LATENCY = 4;
   localparam int PIX_CNT_W   = 19;

   typedef struct packed {
      logic [5:0] hue;
      logic [4:0] sat;
      logic [4:0] val;
   } hsv_t;

   typedef struct packed {
      logic [4:0] r;
      logic [5:0] g;
      logic [4:0] b;
   } rgb565_t;

   // Green gains its sixth bit by repeating its MSB, so full-scale 5-bit maps to 63.
   function automatic rgb565_t pack_rgb565(input logic [4:0] r, input logic [4:0] g,
                                          input logic [4:0] b);
      return '{r: r, g: {g, g[4]}, b: b};
   endfunction

endpackage

// File: rtl/hsv2rgb_core.sv
// rtl/hsv2rgb_core.sv - HSV to RGB565 datapath: input register plus stages S1..S4
module hsv2rgb_core
   import cam2vga_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  hsv_t    hsv_in,
   output rgb565_t rgb_out
);

   hsv_t        in_d, in_q;
   logic [4:0]  v1_d, v1_q, v2_d, v2_q, v3_d, v3_q;
   logic [2:0]  sec1_d, sec1_q, sec2_d, sec2_q, sec3_d, sec3_q;
   logic [5:0]  f1_d, f1_q;
   logic [10:0] vk1_d, vk1_q;
   logic [4:0]  p2_d, p2_q, p3_d, p3_q, q3_d, q3_q, t3_d, t3_q;
   logic [16:0] vkf2_d, vkf2_q, vkg2_d, vkg2_q;
   rgb565_t     rgb_d, rgb_q;
   logic [8:0]  h6;
   logic [6:0]  k;

   always_comb begin
      in_d   = hsv_in;
      // hue*6 puts the sector in the top three bits and the fraction in the low six
      h6     = 9'(in_q.hue) * 9'd6;
      k      = 7'({in_q.sat, in_q.sat[4]}) + 7'd1;
      v1_d   = in_q.val;
      sec1_d = h6[8:6];
      f1_d   = h6[5:0];
      vk1_d  = 11'(in_q.val) * 11'(k);

      v2_d   = v1_q;
      sec2_d = sec1_q;
      p2_d   = v1_q - vk1_q[10:6];
      vkf2_d = 17'(vk1_q) * 17'(f1_q);
      vkg2_d = 17'(vk1_q) * 17'(7'd64 - 7'(f1_q));

      v3_d   = v2_q;
      sec3_d = sec2_q;
      p3_d   = p2_q;
      q3_d   = v2_q - vkf2_q[16:12];
      t3_d   = v2_q - vkg2_q[16:12];

      case (sec3_q)
         3'd0:    rgb_d = pack_rgb565(v3_q, t3_q, p3_q);
         3'd1:    rgb_d = pack_rgb565(q3_q, v3_q, p3_q);
         3'd2:    rgb_d = pack_rgb565(p3_q, v3_q, t3_q);
         3'd3:    rgb_d = pack_rgb565(p3_q, q3_q, v3_q);
         3'd4:    rgb_d = pack_rgb565(t3_q, p3_q, v3_q);
         default: rgb_d = pack_rgb565(v3_q, p3_q, q3_q);
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_q   <= '0;
         v1_q   <= '0; sec1_q <= '0; f1_q   <= '0; vk1_q  <= '0;
         v2_q   <= '0; sec2_q <= '0; p2_q   <= '0; vkf2_q <= '0; vkg2_q <= '0;
         v3_q   <= '0; sec3_q <= '0; p3_q   <= '0; q3_q   <= '0; t3_q   <= '0;
         rgb_q  <= '0;
      end else begin
         in_q   <= in_d;
         v1_q   <= v1_d; sec1_q <= sec1_d; f1_q   <= f1_d; vk1_q  <= vk1_d;
         v2_q   <= v2_d; sec2_q <= sec2_d; p2_q   <= p2_d; vkf2_q <= vkf2_d; vkg2_q <= vkg2_d;
         v3_q   <= v3_d; sec3_q <= sec3_d; p3_q   <= p3_d; q3_q   <= q3_d;   t3_q   <= t3_d;
         rgb_q  <= rgb_d;
      end
   end

   assign rgb_out = rgb_q;

endmodule

// File: rtl/hsv2rgb.sv
// rtl/hsv2rgb.sv - HSV to RGB565 stream converter with frame/data qualifiers and pixel counter
module hsv2rgb
   import cam2vga_pkg::*;
#(
   parameter int PIX_W        = PIX_CNT_W,
   parameter bit ZERO_INVALID = 1'b1
)(
   input  logic             hsv_clk_in,
   input  logic             hsv_rst_in,
   input  logic [15:0]      hsv_in,
   input  logic             hsv_fram_valid,
   input  logic             hsv_data_valid,
   output logic [15:0]      rgb_out,
   output logic             rgb_fram_valid,
   output logic             rgb_data_valid,
   output logic [PIX_W-1:0] rgb_pix_cnt
);

   rgb565_t              core_rgb;
   logic [HSV_LATENCY:0] fv_d, fv_q, dv_d, dv_q;
   logic [PIX_W-1:0]     cnt_d, cnt_q;
   logic                 fv_next, dv_next;

   hsv2rgb_core u_core (
      .clk     (hsv_clk_in),
      .rst     (hsv_rst_in),
      .hsv_in  (hsv_in),
      .rgb_out (core_rgb)
   );

   // Counter looks at the qualifiers about to reach the output so it stays aligned with rgb_out.
   assign fv_next = fv_q[HSV_LATENCY-1];
   assign dv_next = dv_q[HSV_LATENCY-1];

   always_comb begin
      fv_d  = {fv_q[HSV_LATENCY-1:0], hsv_fram_valid};
      dv_d  = {dv_q[HSV_LATENCY-1:0], hsv_data_valid};
      cnt_d = cnt_q;
      if (!fv_next)
         cnt_d = '0;
      else if (dv_next && (cnt_q != {PIX_W{1'b1}}))
         cnt_d = cnt_q + PIX_W'(1);
   end

   always_ff @(posedge hsv_clk_in or posedge hsv_rst_in) begin
      if (hsv_rst_in) begin
         fv_q  <= '0;
         dv_q  <= '0;
         cnt_q <= '0;
      end else begin
         fv_q  <= fv_d;
         dv_q  <= dv_d;
         cnt_q <= cnt_d;
      end
   end

   assign rgb_fram_valid = fv_q[HSV_LATENCY];
   assign rgb_data_valid = dv_q[HSV_LATENCY];
   assign rgb_pix_cnt    = cnt_q;
   assign rgb_out        = (ZERO_INVALID && !dv_q[HSV_LATENCY]) ? 16'h0000 : core_rgb;

endmodule
